// File: rtl/instr_fetch_queue_if.sv
// Bundle of the host-side and Decode-side signals of the instruction fetch queue.
//
// Handshake: an instruction transfers from host to queue on a rising clock
// edge where in_valid and in_ready are both 1. in_ready depends only on
// registered queue state and reset, never on in_valid or stalled. While not
// transferred, the host may drop in_valid or change in_instr at will.
// On the Decode side, out_valid/out_instr are registered. They change only on
// an edge where stalled is 0; with stalled=1 they hold exactly.
interface instr_fetch_queue_if #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               stalled;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [LVL_W-1:0]   level;
  logic [15:0]        issued_cnt;

  // Host/Decode side: drives offers and the stall, observes everything else.
  modport master (
    output in_valid, in_instr, stalled,
    input  in_ready, out_valid, out_instr, level, issued_cnt
  );

  // Queue side.
  modport slave (
    input  in_valid, in_instr, stalled,
    output in_ready, out_valid, out_instr, level, issued_cnt
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO in front of a registered output
// stage feeding Decode. An empty queue bypasses the incoming instruction
// straight into the output register. A NOP bubble is issued when nothing is
// available.
module instr_fetch_queue #(
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic                 clock,
  input logic                 reset,
  instr_fetch_queue_if.slave  bus
);
  localparam int                LVL_W    = $clog2(DEPTH + 1);
  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [15:0]        issued_q;

  logic in_ready;
  logic in_fire;
  logic advance;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;

  // Ready comes from the registered level only, so a pop from a full queue
  // does not open the input until the following cycle.
  assign in_ready   = !reset && (level_q < LVL_FULL);
  assign in_fire    = bus.in_valid && in_ready;
  assign advance    = !bus.stalled;
  assign fifo_empty = (level_q == '0);
  assign pop        = advance && !fifo_empty;
  assign bypass     = advance && fifo_empty && in_fire;
  assign push       = in_fire && !bypass;

  // Pointers, occupancy and the Decode-facing output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      issued_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      if (advance) begin
        if (pop) begin
          out_instr_q <= mem[rd_ptr];
          out_valid_q <= 1'b1;
          issued_q    <= issued_q + 16'd1;
        end else if (bypass) begin
          out_instr_q <= bus.in_instr;
          out_valid_q <= 1'b1;
          issued_q    <= issued_q + 16'd1;
        end else begin
          out_instr_q <= NOP_INSTR;
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.level      = level_q;
  assign bus.issued_cnt = issued_q;

  a_fire_not_full: assert property (@(posedge clock) disable iff (reset)
    in_fire |-> (level_q < LVL_FULL));

  a_pop_not_empty: assert property (@(posedge clock) disable iff (reset)
    pop |-> (level_q != '0));

  a_level_bound: assert property (@(posedge clock) disable iff (reset)
    level_q <= LVL_FULL);

  a_stall_holds: assert property (@(posedge clock) disable iff (reset)
    (bus.stalled && !reset) |=> ($stable(out_valid_q) && $stable(out_instr_q)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_instr_fetch_queue;
  localparam int          INSTR_W = 16;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] NOP     = 16'h0000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  instr_fetch_queue_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  instr_fetch_queue #(
    .INSTR_W   (INSTR_W),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock.
  always #5 clock = ~clock;

  // Reference model: exp_q holds accepted but not yet issued instructions.
  logic [INSTR_W-1:0] exp_q[$];
  logic               m_valid;
  logic [INSTR_W-1:0] m_instr;
  int unsigned        m_issued;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check ready, advance the model, check outputs.
  task automatic cycle(input logic rst, input logic v, input logic [15:0] instr, input logic st);
    logic fire;
    reset        = rst;
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.stalled  = st;
    #1;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && (exp_q.size() < DEPTH))});
    fire = v && !rst && (exp_q.size() < DEPTH);
    @(posedge clock);
    #1;
    if (rst) begin
      exp_q.delete();
      m_valid  = 1'b0;
      m_instr  = NOP;
      m_issued = 0;
    end else begin
      // An accepted instruction joins the back of the line; an advancing
      // Decode takes the front of the line (which may be that same one).
      if (fire) exp_q.push_back(instr);
      if (!st) begin
        if (exp_q.size() > 0) begin
          m_instr = exp_q.pop_front();
          m_valid = 1'b1;
          m_issued++;
        end else begin
          m_instr = NOP;
          m_valid = 1'b0;
        end
      end
    end
    chk("out_valid",  {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("out_instr",  {16'd0, bus.out_instr}, {16'd0, m_instr});
    chk("level",      {29'd0, bus.level},     exp_q.size());
    chk("issued_cnt", {16'd0, bus.issued_cnt}, m_issued & 32'hFFFF);
  endtask

  int          idx;
  int          guard;
  int unsigned base;
  logic        acc;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.stalled  = 1'b0;
    exp_q.delete();
    m_valid  = 1'b0;
    m_instr  = NOP;
    m_issued = 0;

    // Reset, then idle.
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_out_instr", {16'd0, bus.out_instr}, 32'h0000);
    chk("idle_level",     {29'd0, bus.level},     32'd0);
    chk("idle_issued",    {16'd0, bus.issued_cnt}, 32'd0);
    chk("idle_in_ready",  {31'd0, bus.in_ready},  32'd1);

    // Single instruction through an empty queue: bypass, then a bubble.
    cycle(1'b0, 1'b1, 16'hA123, 1'b0);
    chk("bypass_instr",  {16'd0, bus.out_instr}, 32'hA123);
    chk("bypass_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("bypass_level",  {29'd0, bus.level},     32'd0);
    chk("bypass_issued", {16'd0, bus.issued_cnt}, 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("bubble_valid", {31'd0, bus.out_valid}, 32'd0);

    // Fill while stalled; the fifth offer is refused.
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 16'(i), 1'b1);
    chk("full_level",    {29'd0, bus.level},    32'd4);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      chk("drain_order", {16'd0, bus.out_instr}, 32'(i));
    end

    // Full queue under continuous offers: steady flow across pointer wraps.
    for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b1);
    for (int i = 4; i < 20; i++) cycle(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("stream_drained", {29'd0, bus.level}, 32'd0);

    // Stall toggling every cycle during a 10-instruction stream.
    base  = m_issued;
    idx   = 0;
    guard = 0;
    while (idx < 10 && guard < 100) begin
      acc = (exp_q.size() < DEPTH);
      cycle(1'b0, 1'b1, 16'h2000 + 16'(idx), guard[0]);
      if (acc) idx++;
      guard++;
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0, i[0]);
    chk("toggle_issued", {16'd0, bus.issued_cnt}, (base + 10) & 32'hFFFF);

    // Reset with three queued entries and a valid presented instruction.
    cycle(1'b0, 1'b1, 16'h3000, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 16'h3000 + 16'(i), 1'b1);
    chk("pre_reset_level", {29'd0, bus.level},     32'd3);
    chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    cycle(1'b1, 1'b1, 16'h3333, 1'b0);
    chk("rst_out_valid", {31'd0, bus.out_valid},  32'd0);
    chk("rst_out_instr", {16'd0, bus.out_instr},  32'h0000);
    chk("rst_level",     {29'd0, bus.level},      32'd0);
    chk("rst_issued",    {16'd0, bus.issued_cnt}, 32'd0);
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("after_rst_instr",  {16'd0, bus.out_instr},  32'hBEEF);
    chk("after_rst_issued", {16'd0, bus.issued_cnt}, 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            16'($urandom),
            ($urandom_range(0, 2) == 0));
    end
    repeat (6) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("final_level", {29'd0, bus.level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Upstream instruction-issue stage that feeds the Decode stage of the pipelined microcontroller.
- Accepts instructions from the testbench/host over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents one registered instruction per cycle to Decode, holding it while Decode reports `stalled`.
- Injects NOP bubbles when no instruction is available.

Parameters:
- INSTR_W, 16, instruction word width in bits.
- DEPTH, 4, FIFO entries, excluding the output register; power of two, at least 2.
- NOP_INSTR, 16'h0000, encoding driven on `out_instr` for a bubble.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  host offers `in_instr` this cycle.
- in_instr  input  INSTR_W  instruction from host.
- in_ready  output  1  queue can accept this cycle.
- stalled  input  1  Decode stall; output register must hold.
- out_valid  output  1  `out_instr` is a real instruction (0 = bubble).
- out_instr  output  INSTR_W  instruction presented to Decode.
- level  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register.
- issued_cnt  output  16  count of valid instructions handed to Decode; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (synchronous, active-high, clock/reset already decided as above):
  - At the edge with `reset`=1: `out_valid`=0, `out_instr`=NOP_INSTR, `level`=0, `issued_cnt`=0, read/write pointers cleared.
  - `in_ready`=0 while `reset` is high; FIFO contents are don't-care.
  - Reset mid-operation discards all queued and presented instructions; no partial pops or pushes.
- in_ready = !reset && (level < DEPTH).
  - Registered-level based only; no combinational path from `stalled` or `in_valid`.
  - When full, a simultaneous pop does not raise `in_ready` in the same cycle.
- in_fire = in_valid && in_ready. Host may drop `in_valid` or change `in_instr` freely when not fired.
- advance = !stalled. Output register updates only on advance; with `stalled`=1, `out_valid` and `out_instr` hold exactly, including holding a bubble.
- On advance, priority order:
  - a) level>0: output <= FIFO head, `out_valid`=1, pop.
  - b) level==0 and in_fire: bypass, output <= `in_instr`, `out_valid`=1, no push.
  - c) otherwise: output <= NOP_INSTR, `out_valid`=0.
- Push: in_fire and not bypassed (case b) → write at wr_ptr, wr_ptr++ modulo DEPTH.
- Level update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Latency:
  - Empty queue, not stalled: instruction fired at edge N is on `out_instr` after edge N (visible cycle N+1).
  - Otherwise strict FIFO order; no reordering and no loss.
- issued_cnt increments by 1 at each advance that loads `out_valid`=1 (cases a and b).
- Pointers wrap modulo DEPTH. `level` never exceeds DEPTH or goes below 0; the assertions below cover both.
- Assertions:
  - in_fire implies level<DEPTH.
  - pop implies level>0.
  - `stalled` held implies `out_*` stable.

Test Plan:
- Reset then idle 5 cycles, `stalled`=0 → `out_valid`=0, `out_instr`=16'h0000, `in_ready`=1, `level`=0, `issued_cnt`=0.
- Single fire 16'hA123 into empty queue, `stalled`=0 → next cycle `out_instr`=16'hA123, `out_valid`=1, `level` stays 0, `issued_cnt`=1; following cycle bubble.
- Hold `stalled`=1, fire 16'h0001..16'h0005 on consecutive cycles → first four accepted (`level`=4), `in_ready`=0 on the fifth; release stall → outputs 0001,0002,0003,0004 on consecutive cycles; `in_ready` returns 1 the cycle after the first pop.
- Full queue, `stalled`=0, `in_valid`=1 continuous → one push and one pop per cycle after `in_ready` recovers; `level` steady; order preserved across ≥3 pointer wraps (≥12 instructions).
- `stalled` toggled 1/0 every cycle during a 10-instruction stream → each instruction seen exactly once with `out_valid`=1 in order; `out_instr` stable during every stalled cycle; `issued_cnt`=10.
- `reset` asserted for 1 cycle with `level`=3 and `out_valid`=1 → next cycle all outputs at reset values; subsequently fired 16'hBEEF is the first instruction issued.
